// File: rtl/pseudo_lru_tree_if.sv
// Bundle between a cache controller and the tree pseudo-LRU replacement tracker.
// The master side records accesses and asks for victims; the slave side answers them.
interface pseudo_lru_tree_if #(
   parameter int WAYS = 16,
   parameter int SETS = 8
);
   localparam int WAY_W = $clog2(WAYS);
   localparam int IDX_W = $clog2(SETS);

   logic             flush;
   logic             touch;
   logic [IDX_W-1:0] touch_set;
   logic [WAY_W-1:0] touch_way;
   logic             victim_req;
   logic [IDX_W-1:0] victim_set;
   logic [WAYS-1:0]  valid_mask;
   logic [WAYS-1:0]  lock_mask;
   logic             busy;
   logic             victim_valid;
   logic [WAY_W-1:0] victim_way;
   logic             victim_none;

   modport master (
      output flush, touch, touch_set, touch_way,
      output victim_req, victim_set, valid_mask, lock_mask,
      input  busy, victim_valid, victim_way, victim_none
   );

   modport slave (
      input  flush, touch, touch_set, touch_way,
      input  victim_req, victim_set, valid_mask, lock_mask,
      output busy, victim_valid, victim_way, victim_none
   );
endinterface

// File: rtl/pseudo_lru_tree.sv
// Tree pseudo-LRU tracker: one heap-ordered bit tree per set, touch updates the access path,
// victim requests walk the tree and apply invalid/lock priorities, answered one cycle later.
module pseudo_lru_tree #(
   parameter int WAYS = 16,
   parameter int SETS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   pseudo_lru_tree_if.slave     bus
);
   localparam int WAY_W = $clog2(WAYS);
   localparam int IDX_W = $clog2(SETS);
   localparam int NODES = WAYS - 1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [IDX_W-1:0] r_ctr;
   logic [IDX_W-1:0] w_ctr_next;
   logic             w_init_we;
   logic             w_run;

   logic [NODES-1:0] r_tree [SETS];
   logic [NODES-1:0] w_touch_row;
   logic [NODES-1:0] w_victim_row;
   logic [NODES-1:0] w_path_mask;
   logic [NODES-1:0] w_path_val;
   logic [WAY_W-1:0] w_lvl_node [WAY_W];

   logic [WAY_W-1:0] w_tree_way;
   logic [WAY_W-1:0] w_inv_way;
   logic             w_inv_found;
   logic [WAY_W-1:0] w_unl_way;
   logic             w_unl_found;
   logic [WAY_W-1:0] w_sel_way;
   logic             w_sel_none;
   logic             w_touch_we;
   logic             w_victim_go;

   logic             r_victim_valid;
   logic [WAY_W-1:0] r_victim_way;
   logic             r_victim_none;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_INIT;
         r_ctr   <= '0;
      end else begin
         r_state <= w_state_next;
         r_ctr   <= w_ctr_next;
      end
   end

   // A flush in either state restarts the sweep; the flush cycle itself writes nothing.
   always_comb begin
      w_state_next = r_state;
      w_ctr_next   = r_ctr;
      w_init_we    = 1'b0;
      w_run        = 1'b0;
      case (r_state)
         ST_INIT: begin
            if (bus.flush) begin
               w_ctr_next = '0;
            end else begin
               w_init_we  = 1'b1;
               w_ctr_next = r_ctr + 1'b1;
               if (r_ctr == IDX_W'(SETS - 1)) begin
                  w_state_next = ST_RUN;
                  w_ctr_next   = '0;
               end
            end
         end
         ST_RUN: begin
            if (bus.flush) begin
               w_state_next = ST_INIT;
               w_ctr_next   = '0;
            end else begin
               w_run = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_INIT;
            w_ctr_next   = '0;
         end
      endcase
   end

   assign w_touch_we  = w_run && bus.touch && !rst;
   assign w_victim_go = w_run && bus.victim_req;

   // Node on the touch path at each level: level base plus the way's top bits.
   generate
      for (genvar gi = 0; gi < WAY_W; gi++) begin : g_path
         localparam int BASE = (1 << gi) - 1;
         assign w_lvl_node[gi] = WAY_W'(BASE) + WAY_W'(bus.touch_way >> (WAY_W - gi));
      end
   endgenerate

   always_comb begin
      w_path_mask = '0;
      w_path_val  = '0;
      for (int l = 0; l < WAY_W; l++) begin
         w_path_mask[w_lvl_node[l]] = 1'b1;
         w_path_val[w_lvl_node[l]]  = bus.touch_way[WAY_W-1-l];
      end
   end

   assign w_touch_row  = r_tree[bus.touch_set];
   assign w_victim_row = r_tree[bus.victim_set];

   always_ff @(posedge clk) begin
      if (w_init_we && !rst) begin
         r_tree[r_ctr] <= '1;
      end else if (w_touch_we) begin
         r_tree[bus.touch_set] <= (w_touch_row & ~w_path_mask) | (w_path_val & w_path_mask);
      end
   end

   // Walk: a set bit points at the lower child, a clear bit at the upper child.
   always_comb begin
      logic [WAY_W-1:0] node;
      logic [WAY_W:0]   node_wide;
      w_tree_way = '0;
      node       = '0;
      node_wide  = '0;
      for (int l = 0; l < WAY_W; l++) begin
         if (w_victim_row[node]) begin
            node_wide = {node, 1'b0} + 1'b1;
         end else begin
            node_wide = {node, 1'b0} + 2'd2;
            w_tree_way[WAY_W-1-l] = 1'b1;
         end
         node = node_wide[WAY_W-1:0];
      end
   end

   always_comb begin
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      w_unl_found = 1'b0;
      w_unl_way   = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!bus.valid_mask[i] && !bus.lock_mask[i]) begin
            w_inv_found = 1'b1;
            w_inv_way   = WAY_W'(i);
         end
         if (!bus.lock_mask[i]) begin
            w_unl_found = 1'b1;
            w_unl_way   = WAY_W'(i);
         end
      end
   end

   always_comb begin
      w_sel_way  = '0;
      w_sel_none = 1'b0;
      if (w_inv_found) begin
         w_sel_way = w_inv_way;
      end else if (!bus.lock_mask[w_tree_way]) begin
         w_sel_way = w_tree_way;
      end else if (w_unl_found) begin
         w_sel_way = w_unl_way;
      end else begin
         w_sel_none = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_victim_valid <= 1'b0;
         r_victim_way   <= '0;
         r_victim_none  <= 1'b0;
      end else begin
         r_victim_valid <= w_victim_go;
         r_victim_way   <= w_victim_go ? w_sel_way : '0;
         r_victim_none  <= w_victim_go && w_sel_none;
      end
   end

   assign bus.busy         = (r_state == ST_INIT);
   assign bus.victim_valid = r_victim_valid;
   assign bus.victim_way   = r_victim_way;
   assign bus.victim_none  = r_victim_none;
endmodule

// File: doc/pseudo_lru_tree.md
PSEUDO_LRU_TREE -- requirements
Module: pseudo_lru_tree

Interface
REQ-001 Parameter WAYS, default 16, associativity; power of two, 2..16.
REQ-002 Parameter SETS, default 8, number of independently tracked sets; power of two, 2..256.
REQ-003 Derived: WAY_W = log2(WAYS), IDX_W = log2(SETS), NODES = WAYS-1 tree bits per set.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 flush  in  1  pulse; restarts the init sweep of all sets.
REQ-008 touch  in  1  record an access to touch_way in set touch_set.
REQ-009 touch_set  in  IDX_W  set index for touch.
REQ-010 touch_way  in  WAY_W  way accessed.
REQ-011 victim_req  in  1  request a replacement choice for victim_set.
REQ-012 victim_set  in  IDX_W  set index for victim_req.
REQ-013 valid_mask  in  WAYS  per-way valid bits of victim_set, sampled with victim_req.
REQ-014 lock_mask  in  WAYS  per-way pinned bits of victim_set; locked ways never chosen.
REQ-015 busy  out  1  init sweep in progress.
REQ-016 victim_valid  out  1  one-cycle pulse; victim_way/victim_none are valid.
REQ-017 victim_way  out  WAY_W  chosen way.
REQ-018 victim_none  out  1  all ways locked; victim_way is 0 and meaningless.

Function
REQ-019 Storage SHALL be SETS x NODES bits in heap order: node n has children 2n+1 (lower half) and 2n+2 (upper half); leaves map to ways 0..WAYS-1 left to right.
REQ-020 Touch: each node on the path to touch_way SHALL be written 0 if touch_way lies in that node's lower half, 1 if in its upper half; nodes off the path are unchanged.
REQ-021 Tree walk: from node 0, bit 1 -> descend to lower child, bit 0 -> descend to upper child; the reached leaf is tree_way.
REQ-022 Victim priority: (a) lowest-index way with valid_mask=0 and lock_mask=0; else (b) tree_way if unlocked; else (c) lowest-index unlocked way; else victim_none=1, victim_way=0.
REQ-023 Latency: victim_req sampled at edge N SHALL produce victim_valid=1 with result during cycle N+1, computed from tree bits as they stood before edge N.
REQ-024 victim_req does not modify tree state; the cache issues a touch for the filled way.
REQ-025 Same-cycle touch and victim_req on the same set: victim uses pre-touch bits; touch commits at the same edge.
REQ-026 State machine: INIT (busy=1) writes all-ones to set ctr, ctr increments per cycle; after writing set SETS-1 -> RUN (busy=0).
REQ-027 In INIT, touch and victim_req SHALL be ignored; victim_valid stays 0.
REQ-028 flush in RUN -> INIT with ctr=0; flush in INIT restarts ctr at 0; flush has priority over touch in the same cycle.
REQ-029 Out-of-range touch_way cannot occur (WAY_W exact); no other error checks.

Reset
REQ-030 rst SHALL force INIT with ctr=0, busy=1, victim_valid=0, victim_way=0, victim_none=0, overriding flush/touch/victim_req.
REQ-031 rst mid-sweep or mid-request SHALL restart the sweep at set 0 and drop any pending victim result.
REQ-032 busy SHALL deassert exactly SETS cycles after rst is released; every set then holds all-ones (victim way 0 with all valid, none locked).

Verification (WAYS=16, SETS=4)
REQ-033 Release rst -> busy=1 for 4 cycles; then victim_req set 2, valid all 1, lock 0 -> next cycle victim_valid=1, victim_way=0.
REQ-034 touch set 1 way 0; victim_req set 1 -> victim_way=8; then touch set 1 way 8; victim_req set 1 -> victim_way=4; set 0 still gives way 0.
REQ-035 Set 3 all valid except ways 5 and 9 invalid, lock 0 -> victim_way=5; lock way 5 -> victim_way=9.
REQ-036 Set 0 all valid, lock_mask=16'hFFFE -> victim_way=0 (tree_way 0 unlocked); lock_mask=16'h0001 -> victim_way=1; lock_mask=16'hFFFF -> victim_none=1.
REQ-037 Same cycle touch set 1 way 0 and victim_req set 1 (fresh) -> victim_way=0; following request -> 8.
REQ-038 flush in RUN after touches -> busy=1 4 cycles, victim_req during busy gives no victim_valid; after, set 1 -> way 0; rst asserted during sweep restarts 4-cycle busy.
